regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline write-back path and a long-latency result unit (load return, multi-cycle ALU).
- Tracks destination registers with outstanding long-latency results in a scoreboard.
- Raises a decode stall on RAW hazards against pending registers, or when pipeline write-back is blocked.
- Sits between MEM/WB, the long-latency unit, decode and the register file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_scoreboard.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// Optional feature macro used by the top: REGFILE_STARVE_GUARD_EN.
package regfile_wb_arbiter_pkg;

  // Default number of waiting cycles before the long-latency unit takes priority.
  localparam int STARVE_LIMIT_DEFAULT = 4;

  // Which requester owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_SEL_NONE = 2'd0,
    WB_SEL_PIPE = 2'd1,
    WB_SEL_LONG = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register
// (register 0 is hard-wired clear), with the lookups the arbiter needs.
module regfile_wb_arbiter_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] p_waddr,
  output logic              p_pending,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              raw_hazard
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Clear first, then set, so a same-cycle issue to a retiring register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[set_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard state; reset discards every outstanding result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  // An issue may reuse a pending destination only when that result retires this cycle.
  assign iss_ready  = (iss_rd == '0) | ~pending_q[iss_rd] | (clr_en & (clr_addr == iss_rd));
  assign p_pending  = (p_waddr != '0) & pending_q[p_waddr];
  assign raw_hazard = (re1 & (raddr1 != '0) & pending_q[raddr1]) |
                      (re2 & (raddr2 != '0) & pending_q[raddr2]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline write-back
// and a long-latency result unit, tracks outstanding destinations and raises
// the decode stall. Optional macro REGFILE_STARVE_GUARD_EN adds a starvation
// counter that hands priority to the long-latency unit after STARVE_LIMIT waits.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_ready,
  input  logic              l_valid,
  input  logic [ADDR_W-1:0] l_waddr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ready,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              stall_req
);

  wb_sel_e           sel;
  logic              p_pending;
  logic              raw_hazard;
  logic              p_elig;
  logic              l_prio;
  logic              issue_fire;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef REGFILE_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign l_prio = (starve_q == CNT_W'(STARVE_LIMIT));

  // Count cycles the long unit waits; cleared once served or when it withdraws.
  always_comb begin
    starve_d = starve_q;
    if (!l_valid || l_ready) starve_d = '0;
    else if (!l_prio)        starve_d = starve_q + 1'b1;
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`else
  // Without the guard the pipeline always wins and the limit has no effect.
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign l_prio = 1'b0;
`endif

  // A pipeline write to a register still awaiting a long result must wait (WAW).
  assign p_elig     = p_we & ~p_pending;
  assign issue_fire = iss_valid & iss_ready & (iss_rd != '0);

  regfile_wb_arbiter_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (issue_fire),
    .set_addr   (iss_rd),
    .clr_en     (l_ready),
    .clr_addr   (l_waddr),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .p_waddr    (p_waddr),
    .p_pending  (p_pending),
    .re1        (re1),
    .raddr1     (raddr1),
    .re2        (re2),
    .raddr2     (raddr2),
    .raw_hazard (raw_hazard)
  );

  // Single-grant arbitration: starved long unit first, then pipeline, then long unit.
  always_comb begin
    sel = WB_SEL_NONE;
    if (l_valid && l_prio) sel = WB_SEL_LONG;
    else if (p_elig)       sel = WB_SEL_PIPE;
    else if (l_valid)      sel = WB_SEL_LONG;
  end

  assign p_ready   = (sel == WB_SEL_PIPE);
  assign l_ready   = (sel == WB_SEL_LONG);
  assign stall_req = raw_hazard | (p_we & ~p_ready);

  // Next write-port contents; writes to register 0 are granted but suppressed.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (sel)
      WB_SEL_PIPE: begin
        we_d    = (p_waddr != '0);
        waddr_d = p_waddr;
        wdata_d = p_wdata;
      end
      WB_SEL_LONG: begin
        we_d    = (l_waddr != '0);
        waddr_d = l_waddr;
        wdata_d = l_wdata;
      end
      default: ;
    endcase
  end

  // Registered write port: a grant appears on the register file one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a behavioural model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rd = '0;
  logic          iss_ready;
  logic          p_we = 1'b0;
  logic [AW-1:0] p_waddr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic          p_ready;
  logic          l_valid = 1'b0;
  logic [AW-1:0] l_waddr = '0;
  logic [DW-1:0] l_wdata = '0;
  logic          l_ready;
  logic          re1 = 1'b0;
  logic [AW-1:0] raddr1 = '0;
  logic          re2 = 1'b0;
  logic [AW-1:0] raddr2 = '0;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          stall_req;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata), .p_ready(p_ready),
    .l_valid(l_valid), .l_waddr(l_waddr), .l_wdata(l_wdata), .l_ready(l_ready),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .we(we), .waddr(waddr), .wdata(wdata), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0]     m_pending = '0;   // set of registers with outstanding long results
  int            m_wait = 0;       // consecutive cycles the long unit has waited
  bit            m_we = 1'b0;
  bit [AW-1:0]   m_waddr = '0;
  bit [DW-1:0]   m_wdata = '0;

  // Who gets the write port given the model state and the current requests.
  function automatic void model_grant(output bit pg, output bit lg);
    bit p_ok;
    bit l_first;
    p_ok = p_we && !(p_waddr != 0 && m_pending[p_waddr]);
`ifdef REGFILE_STARVE_GUARD_EN
    l_first = (m_wait >= SL);
`else
    l_first = 1'b0;
`endif
    lg = l_valid && (l_first || !p_ok);
    pg = p_ok && !lg;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit pg, lg;
    bit [31:0] nxt;
    if (!rst) begin
      m_pending <= '0;
      m_wait    <= 0;
      m_we      <= 1'b0;
      m_waddr   <= '0;
      m_wdata   <= '0;
    end else begin
      model_grant(pg, lg);
      nxt = m_pending;
      if (lg) nxt[l_waddr] = 1'b0;
      if (iss_valid && iss_rd != 0 &&
          (!m_pending[iss_rd] || (lg && l_waddr == iss_rd))) nxt[iss_rd] = 1'b1;
      m_pending <= nxt;
      m_wait <= (!l_valid || lg) ? 0 : ((m_wait < SL) ? m_wait + 1 : SL);
      m_we <= (pg && p_waddr != 0) || (lg && l_waddr != 0);
      if (pg) begin m_waddr <= p_waddr; m_wdata <= p_wdata; end
      else if (lg) begin m_waddr <= l_waddr; m_wdata <= l_wdata; end
    end
  end

  // Compare process: every falling edge out of reset.
  always @(negedge clk) begin
    bit pg, lg, e_iss, e_stall;
    if (rst) begin
      model_grant(pg, lg);
      e_iss = (iss_rd == 0) || !m_pending[iss_rd] || (lg && l_waddr == iss_rd);
      e_stall = (re1 && raddr1 != 0 && m_pending[raddr1]) ||
                (re2 && raddr2 != 0 && m_pending[raddr2]) || (p_we && !pg);
      chk("m_p_ready", DW'(p_ready), DW'(pg));
      chk("m_l_ready", DW'(l_ready), DW'(lg));
      chk("m_iss_ready", DW'(iss_ready), DW'(e_iss));
      chk("m_stall_req", DW'(stall_req), DW'(e_stall));
      chk("m_we", DW'(we), DW'(m_we));
      chk("m_waddr", DW'(waddr), DW'(m_waddr));
      chk("m_wdata", wdata, m_wdata);
      if (we === 1'b1) $display("WB write reg=%0d data=%h t=%0t", waddr, wdata, $time);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rd = '0; p_we = 0; p_waddr = '0; p_wdata = '0;
    l_valid = 0; l_waddr = '0; l_wdata = '0; re1 = 0; raddr1 = '0; re2 = 0; raddr2 = '0;
  endtask

  initial begin
    idle();
    cyc(); cyc();
    #2;
    chk("rst_we", DW'(we), 0);
    chk("rst_waddr", DW'(waddr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_stall", DW'(stall_req), 0);
    cyc(); rst = 1;

    // RAW hazard resolved by a long result
    cyc(); iss_valid = 1; iss_rd = 5;
    #2 chk("raw_iss_ready", DW'(iss_ready), 1);
    cyc(); iss_valid = 0; re1 = 1; raddr1 = 5;
    #2 chk("raw_stall", DW'(stall_req), 1);
    cyc(); l_valid = 1; l_waddr = 5; l_wdata = 32'hDEADBEEF;
    #2 chk("raw_l_ready", DW'(l_ready), 1);
    cyc(); l_valid = 0;
    #2;
    chk("raw_we", DW'(we), 1);
    chk("raw_waddr", DW'(waddr), 5);
    chk("raw_wdata", wdata, 32'hDEADBEEF);
    chk("raw_stall_drop", DW'(stall_req), 0);
    cyc(); idle();

    // Pipeline vs long-unit conflict
    cyc(); p_we = 1; p_waddr = 3; p_wdata = 32'h0000_3333;
    l_valid = 1; l_waddr = 7; l_wdata = 32'h0000_7777;
`ifdef REGFILE_STARVE_GUARD_EN
    for (int i = 1; i <= 5; i++) begin
      #2;
      chk("starve_p_ready", DW'(p_ready), (i <= 4) ? 1 : 0);
      chk("starve_l_ready", DW'(l_ready), (i == 5) ? 1 : 0);
      if (i == 5) chk("starve_stall", DW'(stall_req), 1);
      cyc();
    end
    l_valid = 0;
    #2;
    chk("starve_we", DW'(we), 1);
    chk("starve_waddr", DW'(waddr), 7);
`else
    for (int i = 0; i < 20; i++) begin
      #2 chk("noguard_l_ready", DW'(l_ready), 0);
      cyc();
    end
`endif
    idle(); cyc();

    // Register 0
    iss_valid = 1; iss_rd = 0;
    #2 chk("r0_iss_ready", DW'(iss_ready), 1);
    cyc(); iss_valid = 0; re1 = 1; raddr1 = 0; p_we = 1; p_waddr = 0; p_wdata = 32'h123;
    #2;
    chk("r0_stall", DW'(stall_req), 0);
    chk("r0_p_ready", DW'(p_ready), 1);
    cyc(); idle();
    #2 chk("r0_we", DW'(we), 0);

    // WAW protection
    cyc(); iss_valid = 1; iss_rd = 9;
    cyc(); p_we = 1; p_waddr = 9; p_wdata = 32'h99;
    #2;
    chk("waw_iss_ready", DW'(iss_ready), 0);
    chk("waw_p_ready", DW'(p_ready), 0);
    chk("waw_stall", DW'(stall_req), 1);
    cyc(); p_we = 0; l_valid = 1; l_waddr = 9; l_wdata = 32'h9999;
    #2;
    chk("waw_l_ready", DW'(l_ready), 1);
    chk("waw_iss_bypass", DW'(iss_ready), 1);
    cyc(); idle(); re1 = 1; raddr1 = 9;
    #2;
    chk("waw_still_pending", DW'(stall_req), 1);
    chk("waw_we", DW'(we), 1);
    cyc(); re1 = 0; l_valid = 1; l_waddr = 9;
    cyc(); idle();

    // Asynchronous reset mid-traffic
    cyc(); iss_valid = 1; iss_rd = 5; p_we = 1; p_waddr = 4; p_wdata = 32'h4444;
    cyc(); idle(); re1 = 1; raddr1 = 5;
    #2;
    chk("arst_pre_we", DW'(we), 1);
    chk("arst_pre_stall", DW'(stall_req), 1);
    #1 rst = 0;
    #1;
    chk("arst_we", DW'(we), 0);
    chk("arst_stall", DW'(stall_req), 0);
    chk("arst_waddr", DW'(waddr), 0);
    cyc(); cyc(); rst = 1;
    #2 chk("arst_pending_clear", DW'(stall_req), 0);
    idle();

    // Randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 600; c++) begin
      cyc();
      if (c == 300) begin
        #1 rst = 0;
        cyc(); cyc(); rst = 1;
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd    = AW'($urandom_range(0, 7));
      p_we      = ($urandom_range(0, 9) < 7);
      p_waddr   = AW'($urandom_range(0, 7));
      p_wdata   = $urandom;
      l_valid   = ($urandom_range(0, 2) != 0);
      l_waddr   = AW'($urandom_range(0, 7));
      l_wdata   = $urandom;
      re1       = $urandom_range(0, 1) == 1;
      raddr1    = AW'($urandom_range(0, 7));
      re2       = $urandom_range(0, 1) == 1;
      raddr2    = AW'($urandom_range(0, 7));
    end
    cyc(); idle();
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
